// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult
//
// Sequential shift-and-add multiplier. It captures an M-bit multiplicand and
// an N-bit multiplier on start, retires one multiplier bit per clock, and then
// presents the exact (M+N)-bit product with a one-cycle done pulse. A
// per-operation mode bit selects unsigned or two's-complement signed
// multiplication.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   start        operation request, sampled only while ready=1
//   signed_mode  0 = unsigned, 1 = two's-complement, captured with start
//   a            M-bit multiplicand, captured with start
//   b            N-bit multiplier, captured with start
//   abort        synchronous cancel of an in-flight operation
//   ready        high while idle
//   busy         high while processing multiplier bits
//   done         one-cycle pulse, p holds a freshly completed product
//   p            product, holds the last completed result
module seq_shift_add_mult #(
    parameter int M = 8,
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [M-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [M+N-1:0]   p
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // The accumulator holds M+1 product bits on top (carry included) and the
    // not-yet-consumed multiplier bits underneath; both shift right together.
    logic [M-1:0]   mag_a;
    logic [M+N:0]   acc;
    logic [CW-1:0]  cnt;
    logic           neg;

    logic [M-1:0]   a_mag_in;
    logic [N-1:0]   b_mag_in;
    logic [M:0]     sum;
    logic [M+N:0]   acc_shift;
    logic [M+N-1:0] result;
    logic           last;

    // Signed operands are reduced to magnitudes; the most negative value maps
    // onto 2^(W-1), which still fits as an unsigned W-bit number.
    always_comb begin
        a_mag_in = a;
        b_mag_in = b;
        if (signed_mode && a[M-1]) begin
            a_mag_in = ~a + M'(1);
        end
        if (signed_mode && b[N-1]) begin
            b_mag_in = ~b + N'(1);
        end
    end

    // One shift-and-add step, plus the sign-corrected product taken from the
    // step's result so it can be registered on the completing edge.
    always_comb begin
        sum = acc[M+N:N];
        if (acc[0]) begin
            sum = acc[M+N:N] + {1'b0, mag_a};
        end
        acc_shift = {1'b0, sum, acc[N-1:1]};
        result    = acc_shift[M+N-1:0];
        if (neg) begin
            result = ~acc_shift[M+N-1:0] + (M+N)'(1);
        end
        last = (cnt == LAST_STEP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort only matters while running; in idle a simultaneous start wins
    // simply because abort is not looked at there.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, stepping and result update. p only moves on the
    // completing edge so it stays stable through later idle and run cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_a <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            p     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_a <= a_mag_in;
                        acc   <= {{(M + 1){1'b0}}, b_mag_in};
                        cnt   <= '0;
                        neg   <= signed_mode & (a[M-1] ^ b[N-1]);
                    end
                end
                RUN: begin
                    if (!abort) begin
                        acc <= acc_shift;
                        cnt <= cnt + CW'(1);
                        if (last) begin
                            p <= result;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb_seq_shift_add_mult
//
// Scoreboard bench for seq_shift_add_mult with M=N=8. Stimulus pushes the
// expected product of every operation that should complete; a monitor pops
// and compares on each done pulse and flags any done with nothing pending.
module tb_seq_shift_add_mult;

    localparam int M = 8;
    localparam int N = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             signed_mode;
    logic [M-1:0]     a;
    logic [N-1:0]     b;
    logic             abort;
    logic             ready;
    logic             busy;
    logic             done;
    logic [M+N-1:0]   p;

    int               checks;
    int               errors;
    int               done_cnt;
    int               pushed_cnt;
    logic [M+N-1:0]   exp_q[$];
    logic [M+N-1:0]   last_result;

    seq_shift_add_mult #(.M(M), .N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .abort       (abort),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .p           (p)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point, shared by stimulus and monitor
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Independent golden product
    function automatic logic [M+N-1:0] golden(input logic sm, input logic [M-1:0] av,
                                              input logic [N-1:0] bv);
        logic signed [M-1:0]   sa;
        logic signed [N-1:0]   sb;
        logic signed [M+N-1:0] sp;
        logic [M+N-1:0]        up;
        sa = av;
        sb = bv;
        sp = sa * sb;
        up = {{N{1'b0}}, av} * {{M{1'b0}}, bv};
        return sm ? sp : up;
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                checkOutput("product", 32'(p), 32'(exp_q.pop_front()));
            end
        end
    end

    // Waits (bounded) for a negedge at which ready is high
    task automatic waitReady();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
        end
    endtask

    // Issues one operation as soon as ready; returns just after the accept edge
    task automatic applyStimulus(input logic sm, input logic [M-1:0] av,
                                 input logic [N-1:0] bv, input logic expect_done,
                                 input logic [M+N-1:0] expected);
        waitReady();
        signed_mode = sm;
        a           = av;
        b           = bv;
        start       = 1'b1;
        if (expect_done) begin
            exp_q.push_back(expected);
            pushed_cnt++;
            last_result = expected;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        int busy_cnt;
        int d0;
        int k;
        logic sm;
        logic [M-1:0] av;
        logic [N-1:0] bv;

        checks      = 0;
        errors      = 0;
        done_cnt    = 0;
        pushed_cnt  = 0;
        last_result = '0;
        start       = 1'b0;
        abort       = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", 32'(ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_p", 32'(p), 32'd0);
        rst = 1'b0;

        // Unsigned max with latency and busy-length measurement
        applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b1, 16'hFE01);
        cyc      = 1;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) break;
            cyc++;
        end
        checkOutput("done_cycle", 32'(cyc), 32'd9);
        checkOutput("busy_cycles", 32'(busy_cnt), 32'd8);
        checkOutput("ready_in_done", 32'(ready), 32'd0);

        // Back-to-back directed vectors, each started the cycle ready rises
        applyStimulus(1'b1, 8'hFD, 8'h05, 1'b1, 16'hFFF1);
        applyStimulus(1'b1, 8'h80, 8'h80, 1'b1, 16'h4000);
        applyStimulus(1'b1, 8'h7F, 8'h80, 1'b1, 16'hC080);
        applyStimulus(1'b0, 8'hFD, 8'h05, 1'b1, 16'h04F1);
        applyStimulus(1'b1, 8'h00, 8'h85, 1'b1, 16'h0000);
        applyStimulus(1'b0, 8'hFF, 8'h00, 1'b1, 16'h0000);

        // Starts pulsed during a run must be ignored
        waitReady();
        d0 = done_cnt;
        applyStimulus(1'b0, 8'h12, 8'h34, 1'b1, 16'h03A8);
        repeat (3) @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitReady();
        checkOutput("single_done", 32'(done_cnt), 32'(d0 + 1));

        // Abort in RUN cycle 4: idle next cycle, no done, p unchanged
        d0 = done_cnt;
        applyStimulus(1'b0, 8'h09, 8'h09, 1'b0, 16'h0000);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abort_ready", 32'(ready), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_p", 32'(p), 32'(last_result));
        repeat (12) @(negedge clk);
        checkOutput("abort_no_done", 32'(done_cnt), 32'(d0));

        // Asynchronous reset between edges in the middle of a run
        applyStimulus(1'b1, 8'h85, 8'h33, 1'b0, 16'h0000);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_p", 32'(p), 32'd0);
        checkOutput("arst_ready", 32'(ready), 32'd1);
        checkOutput("arst_done", 32'(done), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random operations with random gaps and occasional aborts
        for (int n = 0; n < 300; n++) begin
            sm = 1'($urandom_range(0, 1));
            av = M'($urandom);
            bv = N'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                applyStimulus(sm, av, bv, 1'b0, '0);
                k = $urandom_range(1, N);
                repeat (k) @(negedge clk);
                abort = 1'b1;
                @(posedge clk);
                #1;
                abort = 1'b0;
            end else begin
                applyStimulus(sm, av, bv, 1'b1, golden(sm, av, bv));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        waitReady();
        repeat (2) @(negedge clk);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("done_count", 32'(done_cnt), 32'(pushed_cnt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
